// File: rtl/io_controller.sv
// Two-switch debounced I/O block with a 4-register CPU port and a 7-segment hex display.
// Optional display blink is compiled in with `define IO_CTRL_BLINK_EN.

module io_ctrl_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_raw,
  output logic o_db,
  output logic o_chg
);
  localparam int CW = 8;

  logic          r_s1, r_s2, r_db;
  logic [CW-1:0] r_cnt;
  logic          w_hit;

  // o_chg pulses in the same cycle the debounced value flips
  assign w_hit = (r_s2 != r_db) && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign o_db  = r_db;
  assign o_chg = w_hit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_db  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 == r_db) begin
        r_cnt <= '0;
      end else if (w_hit) begin
        r_cnt <= '0;
        r_db  <= r_s2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

module io_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BLINK_CYCLES    = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_sw0,
  input  logic        io_sw1,
  output logic [6:0]  io_display,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack
);
  localparam logic [1:0] A_DISP = 2'd0, A_SW = 2'd1, A_EVT = 2'd2, A_CTRL = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK, S_RELEASE} state_t;

  state_t      r_state;
  logic        r_we;
  logic [1:0]  r_addr;
  logic [3:0]  r_wd;
  logic        r_ack;
  logic [15:0] r_rdata;
  logic [3:0]  r_digit;
  logic        r_en;
  logic [1:0]  r_event;
  logic [6:0]  r_disp;

  logic [1:0]  w_raw, w_db, w_chg;
  logic        w_wr_evt, w_wr_ctrl;
  logic        w_blink, w_blank;
  logic [15:0] w_rd;
  logic [6:0]  w_seg;
  logic        w_unused;

  assign w_unused   = ^{cpu_wdata[15:4], BLINK_CYCLES[0]};
  assign w_raw      = {io_sw1, io_sw0};
  assign io_display = r_disp;
  assign cpu_rdata  = r_rdata;
  assign cpu_ack    = r_ack;
  assign w_wr_evt   = (r_state == S_ACCESS) && r_we && (r_addr == A_EVT);
  assign w_wr_ctrl  = (r_state == S_ACCESS) && r_we && (r_addr == A_CTRL);

  for (genvar g = 0; g < 2; g++) begin : g_sw
    io_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clock (clock),
      .reset (reset),
      .i_raw (w_raw[g]),
      .o_db  (w_db[g]),
      .o_chg (w_chg[g])
    );
  end

  always_comb begin
    w_rd = 16'h0000;
    case (r_addr)
      A_DISP:  w_rd = {12'h000, r_digit};
      A_SW:    w_rd = {14'h0000, w_db};
      A_EVT:   w_rd = {14'h0000, r_event};
      default: w_rd = {14'h0000, w_blink, r_en};
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_addr  <= 2'd0;
      r_wd    <= 4'h0;
      r_ack   <= 1'b0;
      r_rdata <= 16'h0000;
      r_digit <= 4'h0;
      r_en    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: if (cpu_req) begin
          r_we    <= cpu_we;
          r_addr  <= cpu_addr;
          r_wd    <= cpu_wdata[3:0];
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          r_state <= S_ACK;
          r_ack   <= 1'b1;
          r_rdata <= r_we ? 16'h0000 : w_rd;
          if (r_we && r_addr == A_DISP) r_digit <= r_wd;
          if (r_we && r_addr == A_CTRL) r_en    <= r_wd[0];
        end
        S_ACK: begin
          r_state <= S_RELEASE;
          r_ack   <= 1'b0;
          r_rdata <= 16'h0000;
        end
        default: if (!cpu_req) r_state <= S_IDLE;
      endcase
    end
  end

  // A debounced change in the same cycle as a W1C clear leaves the bit set
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_event <= 2'b00;
    else        r_event <= (r_event & ~(w_wr_evt ? r_wd[1:0] : 2'b00)) | w_chg;
  end

`ifdef IO_CTRL_BLINK_EN
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  logic          r_blink;
  logic [BW-1:0] r_bcnt;
  logic          r_bph;

  assign w_blink = r_blink;
  assign w_blank = r_blink & r_bph;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         r_blink <= 1'b0;
    else if (w_wr_ctrl) r_blink <= r_wd[1];
  end

  // Held at zero while blink is off, so each 0->1 starts with a lit period
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_bcnt <= '0;
      r_bph  <= 1'b0;
    end else if (!r_blink) begin
      r_bcnt <= '0;
      r_bph  <= 1'b0;
    end else if (r_bcnt == BW'(BLINK_CYCLES - 1)) begin
      r_bcnt <= '0;
      r_bph  <= ~r_bph;
    end else begin
      r_bcnt <= r_bcnt + 1'b1;
    end
  end
`else
  assign w_blink = 1'b0;
  assign w_blank = 1'b0;
`endif

  always_comb begin
    w_seg = 7'b0000000;
    case (r_digit)
      4'h0: w_seg = 7'b0111111;
      4'h1: w_seg = 7'b0000110;
      4'h2: w_seg = 7'b1011011;
      4'h3: w_seg = 7'b1001111;
      4'h4: w_seg = 7'b1100110;
      4'h5: w_seg = 7'b1101101;
      4'h6: w_seg = 7'b1111101;
      4'h7: w_seg = 7'b0000111;
      4'h8: w_seg = 7'b1111111;
      4'h9: w_seg = 7'b1101111;
      4'hA: w_seg = 7'b1110111;
      4'hB: w_seg = 7'b1111100;
      4'hC: w_seg = 7'b0111001;
      4'hD: w_seg = 7'b1011110;
      4'hE: w_seg = 7'b1111001;
      default: w_seg = 7'b1110001;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_disp <= 7'b0111111;
    else        r_disp <= (r_en && !w_blank) ? w_seg : 7'b0000000;
  end
endmodule

// File: tb/tb_io_controller.sv
// Self-checking bench for io_controller: vector table, randomized bus and switch
// traffic against a register-level model, and hand-built timing corner cases.

module tb_io_controller;
  localparam int DB = 4;
  localparam int BL = 16;
`ifdef IO_CTRL_BLINK_EN
  localparam logic [15:0] CTRL_B1 = 16'h0002;
`else
  localparam logic [15:0] CTRL_B1 = 16'h0000;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_sw0 = 1'b0, io_sw1 = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [1:0]  cpu_addr = 2'd0;
  logic [15:0] cpu_wdata = 16'h0;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;
  logic [6:0]  io_display;

  int n_chk = 0;
  int n_err = 0;

  logic [6:0] seg [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    logic        we;
    logic [1:0]  a;
    logic [15:0] wd;
    logic        chk_rd;
    logic [15:0] exp_rd;
    logic [6:0]  exp_d;
  } vec_t;

  always #5 clock = ~clock;

  io_controller #(.DEBOUNCE_CYCLES(DB), .BLINK_CYCLES(BL)) dut (
    .clock      (clock),
    .reset      (reset),
    .io_sw0     (io_sw0),
    .io_sw1     (io_sw1),
    .io_display (io_display),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ack    (cpu_ack)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Full handshake; dsp is io_display one cycle after the ack cycle
  task automatic xfer(input logic we, input logic [1:0] a, input logic [15:0] wd,
                      output logic [15:0] rd, output logic [6:0] dsp);
    int lat = 0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    do begin
      @(negedge clock);
      lat++;
      if (!cpu_ack) chk("rdata_zero_without_ack", cpu_rdata, 0);
    end while (!cpu_ack && lat < 20);
    chk("ack_latency", lat, 2);
    rd = cpu_rdata;
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clock);
    dsp = io_display;
    chk("ack_single_cycle", cpu_ack, 0);
    @(negedge clock);
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] wd);
    logic [15:0] r; logic [6:0] d;
    xfer(1'b1, a, wd, r, d);
  endtask

  task automatic rd_chk(input string nm, input logic [1:0] a, input logic [15:0] exp);
    logic [15:0] r; logic [6:0] d;
    xfer(1'b0, a, 16'h0, r, d);
    chk(nm, r, exp);
  endtask

  // Debounce rule applied to one switch's per-cycle sample stream
  function automatic void deb_model(input logic [1:0] q[$], input int b,
                                    inout logic deb, output logic changed);
    int run = 0;
    changed = 1'b0;
    foreach (q[i]) begin
      if (q[i][b] != deb) begin
        run++;
        if (run == DB) begin deb = q[i][b]; run = 0; changed = 1'b1; end
      end else run = 0;
    end
  endfunction

  initial begin
    vec_t        vt [14];
    logic [15:0] r;
    logic [6:0]  d;
    logic [3:0]  md;
    logic        me;
    logic [1:0]  mev, m_deb, chg;
    int          acks;

    vt[0]  = '{1'b0, 2'd3, 16'h0000, 1'b1, 16'h0001,  7'h3F};
    vt[1]  = '{1'b1, 2'd0, 16'h000A, 1'b0, 16'h0000,  7'h77};
    vt[2]  = '{1'b0, 2'd0, 16'h0000, 1'b1, 16'h000A,  7'h77};
    vt[3]  = '{1'b1, 2'd0, 16'hFFF3, 1'b0, 16'h0000,  7'h4F};
    vt[4]  = '{1'b0, 2'd0, 16'h0000, 1'b1, 16'h0003,  7'h4F};
    vt[5]  = '{1'b1, 2'd3, 16'h0000, 1'b0, 16'h0000,  7'h00};
    vt[6]  = '{1'b0, 2'd3, 16'h0000, 1'b1, 16'h0000,  7'h00};
    vt[7]  = '{1'b1, 2'd3, 16'h0001, 1'b0, 16'h0000,  7'h4F};
    vt[8]  = '{1'b1, 2'd1, 16'hFFFF, 1'b0, 16'h0000,  7'h4F};
    vt[9]  = '{1'b0, 2'd1, 16'h0000, 1'b1, 16'h0000,  7'h4F};
    vt[10] = '{1'b1, 2'd3, 16'hFFFE, 1'b0, 16'h0000,  7'h00};
    vt[11] = '{1'b0, 2'd3, 16'h0000, 1'b1, CTRL_B1,   7'h00};
    vt[12] = '{1'b1, 2'd3, 16'h0001, 1'b0, 16'h0000,  7'h4F};
    vt[13] = '{1'b0, 2'd2, 16'h0000, 1'b1, 16'h0000,  7'h4F};

    repeat (3) @(negedge clock);
    chk("reset_display", io_display, 7'h3F);
    chk("reset_ack", cpu_ack, 0);
    chk("reset_rdata", cpu_rdata, 0);
    reset = 1'b1;
    @(negedge clock);
    chk("post_reset_display", io_display, 7'h3F);

    foreach (vt[i]) begin
      xfer(vt[i].we, vt[i].a, vt[i].wd, r, d);
      if (vt[i].chk_rd) chk($sformatf("vec%0d_rdata", i), r, vt[i].exp_rd);
      chk($sformatf("vec%0d_display", i), d, vt[i].exp_d);
    end

    // Randomized register traffic, switches static
    md = 4'h3; me = 1'b1; mev = 2'b00; m_deb = 2'b00;
    for (int k = 0; k < 40; k++) begin
      logic [1:0]  a;
      logic        we;
      logic [15:0] wd, exp;
      a = 2'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      wd = 16'($urandom);
      if (a == 2'd3 && CTRL_B1 != 0) wd[1] = 1'b0;
      case (a)
        2'd0: exp = {12'h0, md};
        2'd1: exp = {14'h0, m_deb};
        2'd2: exp = {14'h0, mev};
        default: exp = {15'h0, me};
      endcase
      if (we) begin
        if (a == 2'd0) md = wd[3:0];
        if (a == 2'd2) mev = mev & ~wd[1:0];
        if (a == 2'd3) me = wd[0];
      end
      xfer(we, a, wd, r, d);
      if (!we) chk($sformatf("rand%0d_rdata", k), r, exp);
      chk($sformatf("rand%0d_display", k), d, me ? seg[md] : 7'h00);
    end
    wr(2'd3, 16'h0001);

    // Request held long past its ack is serviced once
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 2'd0; cpu_wdata = 16'h0005; acks = 0;
    repeat (6) begin @(negedge clock); acks += int'(cpu_ack); end
    chk("held_req_ack_count", acks, 1);
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clock);
    rd_chk("held_req_display_reg", 2'd0, 16'h0005);
    chk("held_req_display", io_display, seg[5]);

    // Short glitch must not pass, long run must
    wr(2'd2, 16'h0003);
    io_sw0 = 1'b1; repeat (3) @(negedge clock);
    io_sw0 = 1'b0; repeat (3) @(negedge clock);
    rd_chk("glitch_switch", 2'd1, 16'h0000);
    rd_chk("glitch_event", 2'd2, 16'h0000);
    io_sw0 = 1'b1; repeat (10) @(negedge clock);
    rd_chk("stable_switch", 2'd1, 16'h0001);
    rd_chk("stable_event", 2'd2, 16'h0001);
    wr(2'd2, 16'h0001);
    rd_chk("event_w1c", 2'd2, 16'h0000);
    m_deb = 2'b01;

    // Randomized bouncing on both switches
    for (int rnd = 0; rnd < 6; rnd++) begin
      logic [1:0] q[$];
      logic       db0, db1, c0, c1;
      wr(2'd2, 16'h0003);
      for (int j = 0; j < 6; j++) begin
        logic [1:0] v;
        int len;
        v = 2'($urandom_range(0, 3));
        len = $urandom_range(1, 7);
        repeat (len) q.push_back(v);
      end
      repeat (12) q.push_back(q[$]);
      foreach (q[i]) begin
        {io_sw1, io_sw0} = q[i];
        @(negedge clock);
      end
      db0 = m_deb[0]; db1 = m_deb[1];
      deb_model(q, 0, db0, c0);
      deb_model(q, 1, db1, c1);
      m_deb = {db1, db0};
      chg = {c1, c0};
      rd_chk($sformatf("bounce%0d_switch", rnd), 2'd1, {14'h0, m_deb});
      rd_chk($sformatf("bounce%0d_event", rnd), 2'd2, {14'h0, chg});
    end

    // W1C clear lands in the very cycle sw1's debounced value flips
    wr(2'd2, 16'h0003);
    io_sw1 = ~m_deb[1];
    repeat (4) @(negedge clock);
    wr(2'd2, 16'h0002);
    rd_chk("collision_event", 2'd2, 16'h0002);
    m_deb[1] = ~m_deb[1];
    rd_chk("collision_switch", 2'd1, {14'h0, m_deb});

    // Reset in the middle of a DISPLAY write
    wr(2'd0, 16'h0009);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 2'd0; cpu_wdata = 16'h0005;
    @(negedge clock);
    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clock);
    chk("midreset_ack", cpu_ack, 0);
    chk("midreset_rdata", cpu_rdata, 0);
    @(negedge clock);
    chk("midreset_display", io_display, 7'h3F);
    reset = 1'b1;
    @(negedge clock);
    chk("midreset_no_late_ack", cpu_ack, 0);
    rd_chk("midreset_display_reg", 2'd0, 16'h0000);
    rd_chk("midreset_ctrl", 2'd3, 16'h0001);
    xfer(1'b1, 2'd0, 16'h0007, r, d);
    chk("after_reset_write_display", d, seg[7]);

`ifdef IO_CTRL_BLINK_EN
    // First sample d is index 0; current negedge is index 1
    xfer(1'b1, 2'd3, 16'h0003, r, d);
    chk("blink_first_lit", d, seg[7]);
    for (int i = 1; i < 64; i++) begin
      chk($sformatf("blink_cycle%0d", i), io_display, ((i / BL) % 2 == 0) ? seg[7] : 7'h00);
      @(negedge clock);
    end
    xfer(1'b1, 2'd3, 16'h0001, r, d);
    chk("blink_off_display", d, seg[7]);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
